// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// hazard_scoreboard_ctrl_pkg: shared widths, limits and FSM encodings for the issue controller
package hazard_scoreboard_ctrl_pkg;
  localparam int NREGS = 32;
  localparam int REGNOBITS = 5;
  localparam int MAX_INFLIGHT = 3;
  localparam int CNTW = 2;
  localparam int from_SB_to_DE_WIDTH = 2;
  localparam int from_SB_to_FE_WIDTH = 1;
  typedef enum logic {HZ_IDLE = 1'b0, HZ_BR_WAIT = 1'b1} hz_state_e;
endpackage

// File: rtl/hazard_scoreboard_ctrl_sb_counter_bank.sv
// hazard_scoreboard_ctrl_sb_counter_bank: per-register saturating pending-write counters with retire-bypassed read ports
module hazard_scoreboard_ctrl_sb_counter_bank
  import hazard_scoreboard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_en,
  input  logic [REGNOBITS-1:0] inc_rd,
  input  logic                 dec_en,
  input  logic [REGNOBITS-1:0] dec_rd,
  input  logic [REGNOBITS-1:0] rd_a,
  input  logic [REGNOBITS-1:0] rd_b,
  output logic                 eff_a_nz,
  output logic                 eff_b_nz,
  output logic                 busy,
  output logic                 err
);
  logic [CNTW-1:0] pending [NREGS];
  logic [CNTW-1:0] pending_nxt [NREGS];
  logic [NREGS-1:0] inc_v, dec_v;
  logic err_set;
  // x0 is masked out of both one-hot vectors so it never gets tracked
  assign inc_v = inc_en ? (NREGS'(1) << inc_rd) & ~NREGS'(1) : '0;
  assign dec_v = dec_en ? (NREGS'(1) << dec_rd) & ~NREGS'(1) : '0;
  // a write retiring this cycle lands on the negedge, so it no longer counts as pending
  assign eff_a_nz = (pending[rd_a] - CNTW'(dec_v[rd_a])) != '0;
  assign eff_b_nz = (pending[rd_b] - CNTW'(dec_v[rd_b])) != '0;
  // next counts: saturate at MAX_INFLIGHT and floor at 0, flagging either as an error
  always_comb begin
    pending_nxt = pending;
    err_set = 1'b0;
    busy = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      busy = busy || (pending[r] != '0);
      if (inc_v[r] && !dec_v[r]) begin
        if (pending[r] == CNTW'(MAX_INFLIGHT)) err_set = 1'b1;
        else pending_nxt[r] = pending[r] + CNTW'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        if (pending[r] == '0) err_set = 1'b1;
        else pending_nxt[r] = pending[r] - CNTW'(1);
      end
    end
  end
  // counter state and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '{default: '0};
      err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      err <= err || err_set;
    end
  end
endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl: DE issue/stall control from a pending-write scoreboard plus branch-wait FSM (option HAZARD_PERF_EN adds perf counters)
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 de_wr_reg,
  input  logic                 de_is_ctrl,
  input  logic                 agex_br_resolved,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_rd,
  output logic                 de_issue,
  output logic                 stall_de,
  output logic                 stall_fe,
  output logic                 sb_busy,
`ifdef HAZARD_PERF_EN
  output logic                 sb_err,
  output logic [31:0]          perf_haz_cycles,
  output logic [31:0]          perf_br_cycles
`else
  output logic                 sb_err
`endif
);
  hz_state_e state, state_nxt;
  logic v, bw, haz, eff1_nz, eff2_nz, busy_q, err_q;
  hazard_scoreboard_ctrl_sb_counter_bank u_bank (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (de_issue && de_wr_reg),
    .inc_rd   (de_rd),
    .dec_en   (wb_wr_reg),
    .dec_rd   (wb_rd),
    .rd_a     (de_rs1),
    .rd_b     (de_rs2),
    .eff_a_nz (eff1_nz),
    .eff_b_nz (eff2_nz),
    .busy     (busy_q),
    .err      (err_q)
  );
  // control FSM state register
  always_ff @(posedge clk) begin
    state <= reset ? HZ_IDLE : state_nxt;
  end
  // hazard detect, stall outputs and FSM next state; everything is forced quiet while reset is held
  always_comb begin
    v = de_valid && !reset;
    bw = (state == HZ_BR_WAIT) && !reset;
    haz = (de_rs1_used && de_rs1 != '0 && eff1_nz) || (de_rs2_used && de_rs2 != '0 && eff2_nz);
    stall_de = v && (haz || bw);
    de_issue = v && !stall_de;
    stall_fe = stall_de || (v && de_is_ctrl) || bw;
    sb_busy = busy_q && !reset;
    sb_err = err_q && !reset;
    state_nxt = bw ? (agex_br_resolved ? HZ_IDLE : HZ_BR_WAIT) : (de_issue && de_is_ctrl ? HZ_BR_WAIT : HZ_IDLE);
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] haz_cnt, br_cnt;
  // free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      haz_cnt <= '0;
      br_cnt <= '0;
    end else begin
      haz_cnt <= haz_cnt + 32'(v && haz);
      br_cnt <= br_cnt + 32'(state == HZ_BR_WAIT);
    end
  end
  assign perf_haz_cycles = reset ? '0 : haz_cnt;
  assign perf_br_cycles = reset ? '0 : br_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb_hazard_scoreboard_ctrl: directed scenarios plus randomized traffic against a behavioural scoreboard model
module tb_hazard_scoreboard_ctrl;
  logic clk = 1'b0;
  logic reset, de_valid, de_rs1_used, de_rs2_used, de_wr_reg, de_is_ctrl, agex_br_resolved, wb_wr_reg;
  logic [4:0] de_rs1, de_rs2, de_rd, wb_rd;
  logic de_issue, stall_de, stall_fe, sb_busy, sb_err;
  logic [4:0] outs;
  int checks = 0;
  int passed = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_haz_cycles, perf_br_cycles;
`endif
  always #5 clk = ~clk;
  assign outs = {de_issue, stall_de, stall_fe, sb_busy, sb_err};
  hazard_scoreboard_ctrl dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd), .de_wr_reg(de_wr_reg),
    .de_is_ctrl(de_is_ctrl), .agex_br_resolved(agex_br_resolved), .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd),
    .de_issue(de_issue), .stall_de(stall_de), .stall_fe(stall_fe), .sb_busy(sb_busy),
`ifdef HAZARD_PERF_EN
    .perf_haz_cycles(perf_haz_cycles), .perf_br_cycles(perf_br_cycles),
`endif
    .sb_err(sb_err)
  );

  task automatic step();
    @(negedge clk);
    reset = 0; de_valid = 0; de_rs1 = 0; de_rs1_used = 0; de_rs2 = 0; de_rs2_used = 0;
    de_rd = 0; de_wr_reg = 0; de_is_ctrl = 0; agex_br_resolved = 0; wb_wr_reg = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    step(); reset = 1;
  endtask

  task automatic test_reset();
    step(); reset = 1; de_valid = 1; de_is_ctrl = 1; de_rs1 = 1; de_rs1_used = 1; wb_wr_reg = 1; wb_rd = 2; #1;
    checks++; if (outs !== 5'b00000) $display("FAIL reset_during: got %b want 00000", outs); else passed++;
    step(); #1;
    checks++; if (outs !== 5'b00000) $display("FAIL reset_after: got %b want 00000", outs); else passed++;
`ifdef HAZARD_PERF_EN
    checks++; if ({perf_haz_cycles, perf_br_cycles} !== 64'd0) $display("FAIL reset_perf: got %h want 0", {perf_haz_cycles, perf_br_cycles}); else passed++;
`endif
  endtask

  task automatic test_raw();
    step(); de_valid = 1; de_rd = 5; de_wr_reg = 1; #1;
    checks++; if (outs !== 5'b10000) $display("FAIL raw_issue_writer: got %b want 10000", outs); else passed++;
    for (int i = 0; i < 2; i++) begin
      step(); de_valid = 1; de_rs1 = 5; de_rs1_used = 1; #1;
      checks++; if (outs !== 5'b01110) $display("FAIL raw_stall%0d: got %b want 01110", i, outs); else passed++;
    end
    step(); de_valid = 1; de_rs1 = 5; de_rs1_used = 1; wb_wr_reg = 1; wb_rd = 5; #1;
    checks++; if (outs !== 5'b10010) $display("FAIL raw_retire_bypass: got %b want 10010", outs); else passed++;
    step(); #1;
    checks++; if (outs !== 5'b00000) $display("FAIL raw_drained: got %b want 00000", outs); else passed++;
  endtask

  task automatic test_x0();
    for (int i = 0; i < 2; i++) begin
      step(); de_valid = 1; de_rd = 0; de_wr_reg = 1; #1;
      checks++; if (outs !== 5'b10000) $display("FAIL x0_write%0d: got %b want 10000", i, outs); else passed++;
    end
    step(); de_valid = 1; de_rs1_used = 1; de_rs2_used = 1; #1;
    checks++; if (outs !== 5'b10000) $display("FAIL x0_read: got %b want 10000", outs); else passed++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      step(); de_valid = 1; de_rd = 7; de_wr_reg = 1; #1;
      checks++; if (outs !== (i == 0 ? 5'b10000 : 5'b10010)) $display("FAIL sat_issue%0d: got %b", i, outs); else passed++;
    end
    step(); #1;
    checks++; if (outs !== 5'b00011) $display("FAIL sat_err: got %b want 00011", outs); else passed++;
    for (int i = 0; i < 3; i++) begin
      step(); wb_wr_reg = 1; wb_rd = 7; #1;
      checks++; if (outs !== 5'b00011) $display("FAIL sat_retire%0d: got %b want 00011", i, outs); else passed++;
    end
    step(); wb_wr_reg = 1; wb_rd = 7; #1;
    checks++; if (outs !== 5'b00001) $display("FAIL underflow_retire: got %b want 00001", outs); else passed++;
    step(); de_valid = 1; de_rs1 = 7; de_rs1_used = 1; #1;
    checks++; if (outs !== 5'b10001) $display("FAIL underflow_floor: got %b want 10001", outs); else passed++;
    do_reset();
  endtask

  task automatic test_same_cycle();
    step(); de_valid = 1; de_rd = 9; de_wr_reg = 1; #1;
    checks++; if (outs !== 5'b10000) $display("FAIL same_first: got %b want 10000", outs); else passed++;
    step(); de_valid = 1; de_rd = 9; de_wr_reg = 1; wb_wr_reg = 1; wb_rd = 9; #1;
    checks++; if (outs !== 5'b10010) $display("FAIL same_both: got %b want 10010", outs); else passed++;
    step(); #1;
    checks++; if (outs !== 5'b00010) $display("FAIL same_kept: got %b want 00010", outs); else passed++;
    step(); wb_wr_reg = 1; wb_rd = 9; #1;
    step(); #1;
    checks++; if (outs !== 5'b00000) $display("FAIL same_drain: got %b want 00000", outs); else passed++;
  endtask

  task automatic test_branch();
    step(); agex_br_resolved = 1; #1;
    step(); de_valid = 1; de_is_ctrl = 1; #1;
    checks++; if (outs !== 5'b10100) $display("FAIL br_issue: got %b want 10100", outs); else passed++;
    for (int i = 0; i < 2; i++) begin
      step(); de_valid = 1; #1;
      checks++; if (outs !== 5'b01100) $display("FAIL br_wait%0d: got %b want 01100", i, outs); else passed++;
    end
    step(); de_valid = 1; agex_br_resolved = 1; #1;
    checks++; if (outs !== 5'b01100) $display("FAIL br_resolve: got %b want 01100", outs); else passed++;
    step(); de_valid = 1; #1;
    checks++; if (outs !== 5'b10000) $display("FAIL br_release: got %b want 10000", outs); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      step(); de_valid = 1; de_rd = 3; de_wr_reg = 1; #1;
    end
    step(); de_valid = 1; de_is_ctrl = 1; #1;
    checks++; if (outs !== 5'b10110) $display("FAIL mid_br: got %b want 10110", outs); else passed++;
    step(); de_valid = 1; #1;
    checks++; if (outs !== 5'b01110) $display("FAIL mid_wait: got %b want 01110", outs); else passed++;
    step(); reset = 1; de_valid = 1; #1;
    checks++; if (outs !== 5'b00000) $display("FAIL mid_reset: got %b want 00000", outs); else passed++;
    step(); de_valid = 1; de_rs1 = 3; de_rs1_used = 1; #1;
    checks++; if (outs !== 5'b10000) $display("FAIL mid_after: got %b want 10000", outs); else passed++;
`ifdef HAZARD_PERF_EN
    checks++; if ({perf_haz_cycles, perf_br_cycles} !== 64'd0) $display("FAIL mid_perf: got %h want 0", {perf_haz_cycles, perf_br_cycles}); else passed++;
`endif
  endtask

  task automatic test_random();
    int pend[32];
    bit m_err, m_bw, haz, v, bwv, e_sd, e_is, e_sf, e_busy;
    int e1, e2, inc_r, dec_r;
    int cand[$];
    int m_ph, m_pb;
    do_reset();
    pend = '{default: 0}; m_err = 0; m_bw = 0; m_ph = 0; m_pb = 0;
    for (int n = 0; n < 600; n++) begin
      step();
      reset = ($urandom_range(0, 59) == 0);
      de_valid = ($urandom_range(0, 3) != 0);
      de_rs1 = 5'($urandom_range(0, 7)); de_rs1_used = 1'($urandom_range(0, 1));
      de_rs2 = 5'($urandom_range(0, 7)); de_rs2_used = 1'($urandom_range(0, 1));
      de_rd = 5'($urandom_range(0, 7)); de_wr_reg = ($urandom_range(0, 2) != 0);
      de_is_ctrl = ($urandom_range(0, 7) == 0); agex_br_resolved = ($urandom_range(0, 2) == 0);
      cand.delete();
      for (int r = 1; r < 8; r++) if (pend[r] > 0) cand.push_back(r);
      wb_wr_reg = ($urandom_range(0, 9) < 6);
      wb_rd = (cand.size() > 0 && $urandom_range(0, 9) != 0) ? 5'(cand[$urandom_range(0, cand.size() - 1)]) : 5'($urandom_range(0, 7));
      #1;
      e1 = pend[de_rs1] - ((wb_wr_reg && wb_rd == de_rs1 && de_rs1 != 0) ? 1 : 0);
      e2 = pend[de_rs2] - ((wb_wr_reg && wb_rd == de_rs2 && de_rs2 != 0) ? 1 : 0);
      haz = (de_rs1_used && de_rs1 != 0 && e1 != 0) || (de_rs2_used && de_rs2 != 0 && e2 != 0);
      v = de_valid && !reset; bwv = m_bw && !reset;
      e_sd = v && (haz || bwv); e_is = v && !e_sd; e_sf = e_sd || (v && de_is_ctrl) || bwv;
      e_busy = 0;
      for (int r = 1; r < 32; r++) if (pend[r] != 0) e_busy = 1;
      checks++;
      if (outs !== {e_is, e_sd, e_sf, e_busy && !reset, m_err && !reset})
        $display("FAIL rand_cycle%0d: got %b want %b", n, outs, {e_is, e_sd, e_sf, e_busy && !reset, m_err && !reset});
      else passed++;
`ifdef HAZARD_PERF_EN
      checks++;
      if ({perf_haz_cycles, perf_br_cycles} !== (reset ? 64'd0 : {32'(m_ph), 32'(m_pb)}))
        $display("FAIL rand_perf%0d: got %0d/%0d want %0d/%0d", n, perf_haz_cycles, perf_br_cycles, m_ph, m_pb);
      else passed++;
`endif
      if (reset) begin
        pend = '{default: 0}; m_err = 0; m_bw = 0; m_ph = 0; m_pb = 0;
      end else begin
        m_ph += (v && haz) ? 1 : 0;
        m_pb += m_bw ? 1 : 0;
        inc_r = (e_is && de_wr_reg && de_rd != 0) ? int'(de_rd) : -1;
        dec_r = (wb_wr_reg && wb_rd != 0) ? int'(wb_rd) : -2;
        if (inc_r != dec_r) begin
          if (inc_r > 0) begin if (pend[inc_r] == 3) m_err = 1; else pend[inc_r]++; end
          if (dec_r > 0) begin if (pend[dec_r] == 0) m_err = 1; else pend[dec_r]--; end
        end
        m_bw = m_bw ? !agex_br_resolved : (e_is && de_is_ctrl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_saturate();
    test_same_cycle();
    test_branch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
